// File: rtl/cva6_clic_target_pkg.sv
// Shared types and constants for the CLIC target: FSM states and the {priv, level} rank key.
package cva6_clic_target_pkg;

    localparam int unsigned CLIC_LEVEL_W = 8;

    // riscv::priv_lvl_t encoding: U=0, S=1, M=3
    typedef logic [1:0] priv_lvl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } clic_target_state_e;

    typedef struct packed {
        priv_lvl_t                priv;
        logic [CLIC_LEVEL_W-1:0]  level;
    } clic_rank_t;

    localparam int unsigned CLIC_RANK_W = $bits(clic_rank_t);

endpackage

// File: rtl/cva6_clic_target_max_tree.sv
// Binary max tree over (valid, key, id) leaves; larger key wins, ties go to the lower ID.
module cva6_clic_target_max_tree
    import cva6_clic_target_pkg::*;
#(
    parameter int unsigned NumSrc  = 64,
    parameter int unsigned IdWidth = $clog2(NumSrc)
) (
    input  logic       [NumSrc-1:0]  cand_i,
    input  clic_rank_t [NumSrc-1:0]  key_i,
    output logic                     win_valid_o,
    output logic       [IdWidth-1:0] win_id_o,
    output clic_rank_t               win_key_o
);

    localparam int unsigned Levels = $clog2(NumSrc);
    localparam int unsigned Leaves = 1 << Levels;

    for (genvar l = 0; l <= Levels; l++) begin : g_lvl
        localparam int unsigned N = Leaves >> l;

        logic       [N-1:0]              vld;
        clic_rank_t [N-1:0]              key;
        logic       [N-1:0][IdWidth-1:0] id;

        if (l == 0) begin : g_leaf
            // Leaves beyond NumSrc are padded invalid so any source count works
            for (genvar i = 0; i < N; i++) begin : g_node
                if (i < NumSrc) begin : g_src
                    assign vld[i] = cand_i[i];
                    assign key[i] = key_i[i];
                    assign id[i]  = IdWidth'(i);
                end else begin : g_pad
                    assign vld[i] = 1'b0;
                    assign key[i] = '0;
                    assign id[i]  = '0;
                end
            end
        end else begin : g_cmp
            for (genvar j = 0; j < N; j++) begin : g_node
                logic pick_hi;
                // Upper child only wins on a strictly larger key, so ties keep the lower ID
                assign pick_hi = g_lvl[l-1].vld[2*j+1] &
                                 (~g_lvl[l-1].vld[2*j] |
                                  (g_lvl[l-1].key[2*j+1] > g_lvl[l-1].key[2*j]));
                assign vld[j] = g_lvl[l-1].vld[2*j] | g_lvl[l-1].vld[2*j+1];
                assign key[j] = pick_hi ? g_lvl[l-1].key[2*j+1] : g_lvl[l-1].key[2*j];
                assign id[j]  = pick_hi ? g_lvl[l-1].id[2*j+1]  : g_lvl[l-1].id[2*j];
            end
        end
    end

    assign win_valid_o = g_lvl[Levels].vld[0];
    assign win_key_o   = g_lvl[Levels].key[0];
    assign win_id_o    = g_lvl[Levels].id[0];

endmodule

// File: rtl/cva6_clic_target.sv
// CLIC target: per-source pending tracking, arbitration, and valid/ready + kill/kill-ack
// presentation of the highest-ranked enabled pending interrupt to the core.
module cva6_clic_target
    import cva6_clic_target_pkg::*;
#(
    parameter int unsigned NumSrc  = 64,
    parameter int unsigned IdWidth = $clog2(NumSrc)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumSrc-1:0]         irq_src_i,
    input  logic [NumSrc-1:0]         src_ie_i,
    input  logic [NumSrc-1:0]         src_trig_edge_i,
    input  logic [NumSrc*8-1:0]       src_level_i,
    input  logic [NumSrc*2-1:0]       src_priv_i,
    output logic                      clic_irq_valid_o,
    input  logic                      clic_irq_ready_i,
    output logic [IdWidth-1:0]        clic_irq_id_o,
    output logic [CLIC_LEVEL_W-1:0]   clic_irq_level_o,
    output logic [1:0]                clic_irq_priv_o,
    output logic                      clic_irq_kill_o,
    input  logic                      clic_irq_kill_ack_i
);

    logic [NumSrc-1:0]        src_q;
    logic [NumSrc-1:0]        edge_pend_q, edge_pend_d;
    logic [NumSrc-1:0]        edge_det, pending, cand, acc_clr;
    clic_rank_t [NumSrc-1:0]  key;

    clic_target_state_e       state_q, state_d;
    logic                     valid_q, valid_d;
    logic                     kill_q, kill_d;
    logic [IdWidth-1:0]       id_q, id_d;
    logic [CLIC_LEVEL_W-1:0]  level_q, level_d;
    priv_lvl_t                priv_q, priv_d;
    logic                     accept;

    logic                     win_valid;
    logic [IdWidth-1:0]       win_id;
    clic_rank_t               win_key;
    clic_rank_t               presented_key;

    // Edge sources latch into edge_pend_q; level sources follow the registered line
    assign edge_det = irq_src_i & ~src_q & src_trig_edge_i;
    assign pending  = (src_trig_edge_i & edge_pend_q) | (~src_trig_edge_i & src_q);
    assign cand     = pending & src_ie_i;

    always_comb begin
        key = '0;
        for (int unsigned i = 0; i < NumSrc; i++) begin
            key[i].priv  = src_priv_i[2*i +: 2];
            key[i].level = src_level_i[CLIC_LEVEL_W*i +: CLIC_LEVEL_W];
        end
    end

    cva6_clic_target_max_tree #(
        .NumSrc  (NumSrc),
        .IdWidth (IdWidth)
    ) u_max_tree (
        .cand_i      (cand),
        .key_i       (key),
        .win_valid_o (win_valid),
        .win_id_o    (win_id),
        .win_key_o   (win_key)
    );

    assign presented_key = '{priv: priv_q, level: level_q};

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        kill_d  = kill_q;
        id_d    = id_q;
        level_d = level_q;
        priv_d  = priv_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    id_d    = win_id;
                    level_d = win_key.level;
                    priv_d  = win_key.priv;
                    valid_d = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Acceptance takes precedence over withdrawing a stale request
                if (clic_irq_ready_i) begin
                    valid_d = 1'b0;
                    accept  = 1'b1;
                    state_d = IDLE;
                end else if (!cand[id_q] ||
                             (win_valid && (win_id != id_q) && (win_key > presented_key))) begin
                    valid_d = 1'b0;
                    kill_d  = 1'b1;
                    state_d = KILL;
                end
            end
            KILL: begin
                if (clic_irq_kill_ack_i) begin
                    kill_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                kill_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        acc_clr = '0;
        for (int unsigned i = 0; i < NumSrc; i++) begin
            acc_clr[i] = accept & (id_q == IdWidth'(i)) & src_trig_edge_i[i];
        end
        // A new edge in the accept cycle survives the clear
        edge_pend_d = (edge_pend_q & ~acc_clr) | edge_det;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q       <= '0;
            edge_pend_q <= '0;
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            kill_q      <= 1'b0;
            id_q        <= '0;
            level_q     <= '0;
            priv_q      <= '0;
        end else begin
            src_q       <= irq_src_i;
            edge_pend_q <= edge_pend_d;
            state_q     <= state_d;
            valid_q     <= valid_d;
            kill_q      <= kill_d;
            id_q        <= id_d;
            level_q     <= level_d;
            priv_q      <= priv_d;
        end
    end

    assign clic_irq_valid_o = valid_q;
    assign clic_irq_kill_o  = kill_q;
    assign clic_irq_id_o    = id_q;
    assign clic_irq_level_o = level_q;
    assign clic_irq_priv_o  = priv_q;

endmodule

// File: tb/tb_cva6_clic_target.sv
// Directed bench for cva6_clic_target: expected requests queued at stimulus, checked on valid.
module tb_cva6_clic_target;

    localparam int unsigned NumSrc  = 64;
    localparam int unsigned IdWidth = 6;

    logic                  clk_i;
    logic                  rst_ni;
    logic [NumSrc-1:0]     irq_src_i;
    logic [NumSrc-1:0]     src_ie_i;
    logic [NumSrc-1:0]     src_trig_edge_i;
    logic [NumSrc*8-1:0]   src_level_i;
    logic [NumSrc*2-1:0]   src_priv_i;
    logic                  clic_irq_valid_o;
    logic                  clic_irq_ready_i;
    logic [IdWidth-1:0]    clic_irq_id_o;
    logic [7:0]            clic_irq_level_o;
    logic [1:0]            clic_irq_priv_o;
    logic                  clic_irq_kill_o;
    logic                  clic_irq_kill_ack_i;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [7:0]         level;
        logic [1:0]         priv;
    } req_t;

    req_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    cva6_clic_target #(
        .NumSrc  (NumSrc),
        .IdWidth (IdWidth)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .irq_src_i           (irq_src_i),
        .src_ie_i            (src_ie_i),
        .src_trig_edge_i     (src_trig_edge_i),
        .src_level_i         (src_level_i),
        .src_priv_i          (src_priv_i),
        .clic_irq_valid_o    (clic_irq_valid_o),
        .clic_irq_ready_i    (clic_irq_ready_i),
        .clic_irq_id_o       (clic_irq_id_o),
        .clic_irq_level_o    (clic_irq_level_o),
        .clic_irq_priv_o     (clic_irq_priv_o),
        .clic_irq_kill_o     (clic_irq_kill_o),
        .clic_irq_kill_ack_i (clic_irq_kill_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected finish before 100000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg(input int i, input logic e, input logic [7:0] lvl,
                       input logic [1:0] p, input logic ie);
        src_trig_edge_i[i]  = e;
        src_level_i[8*i +: 8] = lvl;
        src_priv_i[2*i +: 2]  = p;
        src_ie_i[i]         = ie;
    endtask

    task automatic push(input int id, input logic [7:0] lvl, input logic [1:0] p);
        req_t r;
        r.id    = IdWidth'(id);
        r.level = lvl;
        r.priv  = p;
        sb_q.push_back(r);
    endtask

    task automatic pulse(input int i);
        irq_src_i[i] = 1'b1;
        tick();
        irq_src_i[i] = 1'b0;
    endtask

    // Wait (bounded) for a request, then compare it with the oldest queued expectation
    task automatic expect_req(input string tag, input int budget);
        int   n = 0;
        req_t r;
        while (clic_irq_valid_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, ".valid"}, 32'(clic_irq_valid_o), 1);
        check({tag, ".sb_nonempty"}, 32'(sb_q.size() > 0), 1);
        if (clic_irq_valid_o === 1'b1 && sb_q.size() > 0) begin
            r = sb_q.pop_front();
            check({tag, ".id"},    32'(clic_irq_id_o),    32'(r.id));
            check({tag, ".level"}, 32'(clic_irq_level_o), 32'(r.level));
            check({tag, ".priv"},  32'(clic_irq_priv_o),  32'(r.priv));
            check({tag, ".kill"},  32'(clic_irq_kill_o),  0);
        end else if (sb_q.size() > 0) begin
            void'(sb_q.pop_front());
        end
    endtask

    task automatic accept();
        clic_irq_ready_i = 1'b1;
        tick();
        clic_irq_ready_i = 1'b0;
    endtask

    task automatic expect_idle(input string tag, input int n);
        int seen = 0;
        for (int c = 0; c < n; c++) begin
            tick();
            if (clic_irq_valid_o !== 1'b0 || clic_irq_kill_o !== 1'b0) seen++;
        end
        check(tag, 32'(seen), 0);
    endtask

    initial begin
        rst_ni              = 1'b0;
        irq_src_i           = '0;
        src_ie_i            = '0;
        src_trig_edge_i     = '0;
        src_level_i         = '0;
        src_priv_i          = '0;
        clic_irq_ready_i    = 1'b0;
        clic_irq_kill_ack_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst.valid", 32'(clic_irq_valid_o), 0);
        check("rst.kill",  32'(clic_irq_kill_o),  0);
        check("rst.id",    32'(clic_irq_id_o),    0);
        check("rst.level", 32'(clic_irq_level_o), 0);
        check("rst.priv",  32'(clic_irq_priv_o),  0);
        rst_ni = 1'b1;
        tick();
        check("rst.release_valid", 32'(clic_irq_valid_o), 0);

        // Single edge source: two-cycle latency, stable hold, clear on accept
        cfg(5, 1'b1, 8'h40, 2'd3, 1'b1);
        push(5, 8'h40, 2'd3);
        pulse(5);
        check("t1.lat1", 32'(clic_irq_valid_o), 0);
        tick();
        check("t1.lat2", 32'(clic_irq_valid_o), 1);
        expect_req("t1.req", 0);
        tick();
        check("t1.hold_valid", 32'(clic_irq_valid_o), 1);
        check("t1.hold_id",    32'(clic_irq_id_o),    5);
        tick();
        clic_irq_ready_i = 1'b1;
        tick();
        clic_irq_ready_i = 1'b0;
        check("t1.drop", 32'(clic_irq_valid_o), 0);
        expect_idle("t1.pend_clr", 6);

        // Privilege dominates level, then ties resolve to the lower ID
        cfg(3, 1'b1, 8'hFF, 2'd1, 1'b1);
        cfg(9, 1'b1, 8'h01, 2'd3, 1'b1);
        push(9, 8'h01, 2'd3);
        push(3, 8'hFF, 2'd1);
        irq_src_i[3] = 1'b1;
        irq_src_i[9] = 1'b1;
        tick();
        irq_src_i[3] = 1'b0;
        irq_src_i[9] = 1'b0;
        expect_req("t2.priv", 4);
        accept();
        expect_req("t2.second", 4);
        accept();
        cfg(2, 1'b1, 8'h80, 2'd3, 1'b1);
        cfg(7, 1'b1, 8'h80, 2'd3, 1'b1);
        push(2, 8'h80, 2'd3);
        push(7, 8'h80, 2'd3);
        irq_src_i[2] = 1'b1;
        irq_src_i[7] = 1'b1;
        tick();
        irq_src_i[2] = 1'b0;
        irq_src_i[7] = 1'b0;
        expect_req("t2.tie", 4);
        accept();
        expect_req("t2.tie_second", 4);
        accept();
        expect_idle("t2.idle", 4);

        // Higher-key arrival kills the presented request; pending of the loser survives
        cfg(4, 1'b1, 8'h20, 2'd3, 1'b1);
        cfg(6, 1'b1, 8'h30, 2'd3, 1'b1);
        push(4, 8'h20, 2'd3);
        pulse(4);
        expect_req("t3.req4", 4);
        pulse(6);
        check("t3.pre_kill",  32'(clic_irq_kill_o),  0);
        check("t3.pre_valid", 32'(clic_irq_valid_o), 1);
        tick();
        check("t3.kill",       32'(clic_irq_kill_o),  1);
        check("t3.kill_valid", 32'(clic_irq_valid_o), 0);
        tick();
        tick();
        check("t3.kill_hold", 32'(clic_irq_kill_o), 1);
        clic_irq_ready_i = 1'b1;
        tick();
        clic_irq_ready_i = 1'b0;
        check("t3.ready_ignored_kill",  32'(clic_irq_kill_o),  1);
        check("t3.ready_ignored_valid", 32'(clic_irq_valid_o), 0);
        clic_irq_kill_ack_i = 1'b1;
        tick();
        clic_irq_kill_ack_i = 1'b0;
        check("t3.ack_kill",  32'(clic_irq_kill_o),  0);
        check("t3.ack_valid", 32'(clic_irq_valid_o), 0);
        push(6, 8'h30, 2'd3);
        expect_req("t3.req6", 1);
        accept();
        push(4, 8'h20, 2'd3);
        expect_req("t3.req4_again", 4);
        accept();
        expect_idle("t3.idle", 4);

        // Ready and kill condition in the same cycle: accept wins
        push(4, 8'h20, 2'd3);
        pulse(4);
        expect_req("t4.req4", 4);
        irq_src_i[6] = 1'b1;
        tick();
        irq_src_i[6] = 1'b0;
        clic_irq_ready_i = 1'b1;
        tick();
        clic_irq_ready_i = 1'b0;
        check("t4.accept_valid", 32'(clic_irq_valid_o), 0);
        check("t4.accept_kill",  32'(clic_irq_kill_o),  0);
        push(6, 8'h30, 2'd3);
        expect_req("t4.req6", 4);
        accept();
        expect_idle("t4.pend4_clr", 4);

        // Level source re-requests after every accept; disable kills it
        cfg(1, 1'b0, 8'h10, 2'd3, 1'b1);
        irq_src_i[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push(1, 8'h10, 2'd3);
            expect_req("t5.level", 4);
            accept();
        end
        push(1, 8'h10, 2'd3);
        expect_req("t5.pre_disable", 4);
        src_ie_i[1] = 1'b0;
        tick();
        check("t5.ie_kill",  32'(clic_irq_kill_o),  1);
        check("t5.ie_valid", 32'(clic_irq_valid_o), 0);
        clic_irq_kill_ack_i = 1'b1;
        tick();
        clic_irq_kill_ack_i = 1'b0;
        check("t5.ack_kill", 32'(clic_irq_kill_o), 0);
        expect_idle("t5.stay_idle", 5);

        // Asynchronous reset while kill is asserted
        src_ie_i[1] = 1'b1;
        push(1, 8'h10, 2'd3);
        expect_req("t6.req1", 4);
        pulse(5);
        tick();
        check("t6.kill", 32'(clic_irq_kill_o), 1);
        irq_src_i[1] = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6.async_valid", 32'(clic_irq_valid_o), 0);
        check("t6.async_kill",  32'(clic_irq_kill_o),  0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        expect_idle("t6.no_req", 6);
        push(5, 8'h40, 2'd3);
        pulse(5);
        expect_req("t6.new_edge", 4);
        accept();
        expect_idle("t6.idle", 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cva6_clic_target.md
Name: cva6_clic_target

Overview:
- Interrupt-side end of the CLIC-to-core interface: collects per-source interrupt lines, tracks pending state and arbitrates the highest-ranked enabled pending source.
- Presents the winner to the core's CLIC controller over a valid/ready handshake, with a kill/kill-ack side channel to withdraw a stale request.
- Sits in the CLIC, between the source/config registers and the core.

Parameters:
- NumSrc, 64, number of interrupt sources; legal range ≥2, power of two not required.
- IdWidth, $clog2(NumSrc), width of the interrupt ID.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- irq_src_i  in  NumSrc  raw interrupt lines, already synchronous to clk_i
- src_ie_i  in  NumSrc  per-source enable
- src_trig_edge_i  in  NumSrc  1 = rising-edge triggered, 0 = level triggered
- src_level_i  in  NumSrc*8  per-source interrupt level, source i at bits [8i+7:8i]
- src_priv_i  in  NumSrc*2  per-source privilege, riscv::priv_lvl_t encoding
- clic_irq_valid_o  out  1  request valid
- clic_irq_ready_i  in  1  core accepted the presented request
- clic_irq_id_o  out  IdWidth  presented ID
- clic_irq_level_o  out  8  presented level
- clic_irq_priv_o  out  2  presented privilege
- clic_irq_kill_o  out  1  withdraw the presented request
- clic_irq_kill_ack_i  in  1  core confirms the withdrawal

Behaviour:
- Reset: all pending bits 0; src_q 0; FSM in IDLE; valid 0, kill 0; id, level and priv outputs 0.
- Edge detect: edge[i] = irq_src_i[i] & ~src_q[i]; src_q is registered every cycle.
- Pending, edge-triggered sources:
  - set on edge[i];
  - cleared when source i is accepted;
  - if set and clear occur in the same cycle, set wins.
- Pending, level-triggered sources: pending[i] = registered irq_src_i[i]; never cleared by acceptance.
- Candidate: pending[i] & src_ie_i[i].
- Rank key: {priv, level}, 10 bits, unsigned; larger key wins; ties go to the lower ID.
- Winner is combinational from the registered pending vector. win_valid = any candidate.
- FSM IDLE:
  - if win_valid: latch winner id, level and priv into the output registers; valid <= 1; go to REQ.
  - else stay.
- FSM REQ:
  - Outputs are held stable.
  - If ready_i: valid <= 0; clear pending of the presented ID if edge-triggered; go to IDLE.
  - Else, if the presented source is no longer a candidate, or a different winner has a strictly greater key: valid <= 0, kill <= 1; go to KILL.
  - ready_i and the kill condition in the same cycle: ready wins, the request is accepted and no kill is issued.
- FSM KILL:
  - valid stays 0; kill is held at 1 until kill_ack_i.
  - On kill_ack_i: kill <= 0; go to IDLE. The pending bit is untouched.
  - ready_i in KILL is ignored.
- Re-arbitration: after returning to IDLE, a new request may issue on the next cycle, which gives a minimum one-cycle bubble between requests.
- Latency: source rises and is sampled at edge k; pending is set after k; valid is asserted after k+1, so two cycles from line to request.
- Equal-key later arrival: does not kill; the key must be strictly greater.
- Config change while in REQ: src_ie_i drop on the presented source triggers a kill. Level/priv changes on the presented source do not alter the latched outputs.
- Reset asserted mid-handshake: immediate return to the reset state; in-flight request and kill are abandoned.

Decomposition:
- Shared package, in the CLIC package alongside riscv::priv_lvl_t usage:
  - clic_target_state_e {IDLE, REQ, KILL};
  - clic_rank_t packed struct {priv[1:0], level[7:0]};
  - constant CLIC_LEVEL_W = 8.
- One sub-module, clic_max_tree:
  - parameterised over NumSrc;
  - binary comparison tree taking valid, key and id per node;
  - ties resolved toward the lower ID;
  - outputs win_valid, win_id and win_key.

Test Plan:
- Single edge source: src 5, edge, level 0x40, priv M, ie=1. Pulse at cycle 0 → valid=1 at cycle 2 with id=5, level=0x40, priv=3. ready at cycle 4 → valid=0 at cycle 5 and pending[5]=0.
- Arbitration and ties:
  - sources 3 (S, 0xFF) and 9 (M, 0x01) pending together → id=9, since priv dominates;
  - sources 2 and 7 both (M, 0x80) → id=2.
- Kill on higher arrival:
  - presenting id 4 (M, 0x20);
  - id 6 (M, 0x30) rises → kill=1 and valid=0 two cycles later; kill held until kill_ack;
  - the following cycle valid=1 with id=6; pending[4] is still 1.
- Simultaneous events: presenting id 4; id 6 (higher) wins arbitration in the same cycle as ready=1 → accept, no kill, pending[4] cleared; next request is id=6.
- Level-triggered and disable:
  - level source 1 held high → re-requested after each accept, repeatedly;
  - drop src_ie_i[1] while presented → kill=1; after kill_ack, valid remains 0.
- Reset mid-KILL: rst_ni low while kill=1 → valid=0, kill=0 and all pending 0 asynchronously; after release, no request until a new edge.
